// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye sprite DMA: controller states and the
// default object-table geometry / main RAM read latency.
package jtpopeye_pkg;

    localparam int OBJ_AW     = 10;
    localparam int RAM_RD_LAT = 2;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        DRAIN,
        RELEASE
    } dma_state_e;

endpackage

// File: rtl/jtpopeye_dma_if.sv
// Bus seen by the sprite DMA: Z80 BUSRQ/BUSAK handshake, main RAM read port
// and the object buffer write port.
interface jtpopeye_dma_if
    import jtpopeye_pkg::*;
#(
    parameter int AW = OBJ_AW
);
    logic          busrq_n;
    logic          busak_n;
    logic          dma_cs;
    logic [AW-1:0] AD_DMA;
    logic [7:0]    DD_DMA;
    logic          INITEO;
    logic [AW-1:0] obj_addr;
    logic [7:0]    obj_data;
    logic          obj_we;

    modport master (
        output busrq_n, dma_cs, AD_DMA, INITEO, obj_addr, obj_data, obj_we,
        input  busak_n, DD_DMA
    );

    modport slave (
        input  busrq_n, dma_cs, AD_DMA, INITEO, obj_addr, obj_data, obj_we,
        output busak_n, DD_DMA
    );
endinterface

// File: rtl/jtpopeye_dma_pipe.sv
// RD_LAT-deep delay line carrying the valid bit and address of each issued
// main RAM read, so the write strobe lines up with the returning data.
module jtpopeye_dma_pipe
    import jtpopeye_pkg::*;
#(
    parameter int AW     = OBJ_AW,
    parameter int RD_LAT = RAM_RD_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr
);
    localparam int SRW = RD_LAT * AW;

    logic [RD_LAT-1:0] vld;
    logic [SRW-1:0]    addr_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld     <= '0;
            addr_sr <= '0;
        end else begin
            vld     <= flush ? '0 : RD_LAT'({vld, in_valid});
            addr_sr <= SRW'({addr_sr, in_addr});
        end
    end

    // A flush also kills the entry leaving this cycle: its data is not trusted
    assign out_valid = vld[RD_LAT-1] & ~flush;
    assign out_addr  = addr_sr[SRW-1 -: AW];

endmodule

// File: rtl/jtpopeye_dma.sv
// Sprite DMA controller: on each vertical blank it takes the Z80 bus and
// copies the object table from main work RAM into the object buffer.
module jtpopeye_dma
    import jtpopeye_pkg::*;
#(
    parameter int AW     = OBJ_AW,
    parameter int RD_LAT = RAM_RD_LAT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           dma_en,
    input  logic           VB,
    jtpopeye_dma_if.master bus,
    output logic           overrun
);
    localparam int DW = $clog2(RD_LAT + 1);

    dma_state_e    state, next_state;
    logic          VBl, trig, lost, issue;
    logic [AW-1:0] rd_cnt, rd_nxt, rewind;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic          initeo, initeo_nxt, overrun_nxt;
    logic          pipe_valid;
    logic [AW-1:0] pipe_addr;

    assign trig  = VB & ~VBl;
    assign lost  = (state == XFER || state == DRAIN) && bus.busak_n;
    assign issue = (state == XFER) && !bus.busak_n;

    // After a bus loss, re-read the bytes that were still in flight
    assign rewind = (rd_cnt >= AW'(RD_LAT)) ? rd_cnt - AW'(RD_LAT) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            VBl       <= 1'b0;
            rd_cnt    <= '0;
            drain_cnt <= '0;
            initeo    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= next_state;
            VBl       <= VB;
            rd_cnt    <= rd_nxt;
            drain_cnt <= drain_nxt;
            initeo    <= initeo_nxt;
            overrun   <= overrun_nxt;
        end
    end

    always_comb begin
        next_state  = state;
        rd_nxt      = rd_cnt;
        drain_nxt   = drain_cnt;
        initeo_nxt  = initeo;
        overrun_nxt = overrun | (trig & (state != IDLE));
        case (state)
            IDLE: begin
                if (trig && dma_en) begin
                    next_state = REQ;
                    rd_nxt     = '0;
                end
            end
            REQ: begin
                if (!bus.busak_n) begin
                    next_state = XFER;
                    initeo_nxt = 1'b1;
                    rd_nxt     = rewind;
                end
            end
            XFER: begin
                drain_nxt = '0;
                if (lost) begin
                    next_state = REQ;
                end else if (&rd_cnt) begin
                    // Hold the terminal address so a loss in DRAIN rewinds correctly
                    next_state = DRAIN;
                end else begin
                    rd_nxt = rd_cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (lost) begin
                    next_state = REQ;
                end else if (drain_cnt == DW'(RD_LAT - 1)) begin
                    next_state = RELEASE;
                end else begin
                    drain_nxt = drain_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (bus.busak_n) begin
                    next_state = IDLE;
                    initeo_nxt = 1'b0;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    jtpopeye_dma_pipe #(
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (lost),
        .in_valid  (issue),
        .in_addr   (rd_cnt),
        .out_valid (pipe_valid),
        .out_addr  (pipe_addr)
    );

    assign bus.busrq_n  = !(state == REQ || state == XFER || state == DRAIN);
    assign bus.dma_cs   = (state == XFER || state == DRAIN) && !bus.busak_n;
    assign bus.AD_DMA   = rd_cnt;
    assign bus.INITEO   = initeo;
    assign bus.obj_we   = pipe_valid;
    assign bus.obj_addr = pipe_valid ? pipe_addr : '0;
    assign bus.obj_data = pipe_valid ? bus.DD_DMA : '0;

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Directed bench for jtpopeye_dma with a Z80 BUSAK model and a 2-clk RAM model.
module tb_jtpopeye_dma;

    logic clk = 1'b0;
    logic rst, dma_en, VB;
    logic overrun;

    jtpopeye_dma_if #(.AW(10)) bus ();

    jtpopeye_dma #(.AW(10), .RD_LAT(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .dma_en  (dma_en),
        .VB      (VB),
        .bus     (bus),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // Z80 grants grant_dly clks after the request; force_hi models bus loss
    int unsigned grant_dly = 3;
    bit          force_hi  = 1'b0;
    int unsigned gcnt      = 0;
    logic        busak_q   = 1'b1;
    logic [9:0]  ram_q     = '0;
    logic [7:0]  dd_q      = '0;

    assign bus.busak_n = busak_q;
    assign bus.DD_DMA  = dd_q;

    always @(posedge clk) begin
        ram_q <= bus.AD_DMA;
        dd_q  <= ram_q[7:0] ^ 8'h5A;
        if (bus.busrq_n || force_hi) begin
            gcnt    <= 0;
            busak_q <= 1'b1;
        end else if (gcnt + 1 >= grant_dly) begin
            busak_q <= 1'b0;
        end else begin
            gcnt <= gcnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc, rq_low, ini_hi, we_cnt, bad_data, cs_no_bus;
    int first_cs, first_ad, first_gnt, first_we, last_we;
    int sb_cnt [1024];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; rq_low = 0; ini_hi = 0; we_cnt = 0; bad_data = 0; cs_no_bus = 0;
        first_cs = -1; first_ad = -1; first_gnt = -1; first_we = -1; last_we = -1;
        for (int i = 0; i < 1024; i++) sb_cnt[i] = 0;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (!bus.busrq_n) rq_low++;
        if (bus.INITEO) ini_hi++;
        if (!bus.busak_n && first_gnt < 0) first_gnt = cyc;
        if (bus.dma_cs && first_cs < 0) begin
            first_cs = cyc;
            first_ad = int'(bus.AD_DMA);
        end
        if (bus.dma_cs && bus.busak_n) cs_no_bus++;
        if (bus.obj_we) begin
            we_cnt++;
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
            sb_cnt[bus.obj_addr]++;
            if (bus.obj_data !== (bus.obj_addr[7:0] ^ 8'h5A)) bad_data++;
        end
    endtask

    task automatic pulse_vb();
        VB = 1'b1;
        step();
        VB = 1'b0;
        step();
    endtask

    task automatic run_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (ini_hi > 0 && !bus.INITEO && bus.busrq_n) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_ad(input string tag, input int unsigned a);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (bus.dma_cs && int'(bus.AD_DMA) == a) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    // Every address written, no duplicates outside the allowed rewind window
    task automatic sb_check(input string tag, input bit allow_rewind);
        int missing = 0;
        int dup = 0;
        for (int i = 0; i < 1024; i++) begin
            if (sb_cnt[i] == 0) missing++;
            if (sb_cnt[i] > 1 && !(allow_rewind && (i == 298 || i == 299))) dup++;
        end
        check({tag, "_missing"}, missing, 0);
        check({tag, "_dup"}, dup, 0);
        check({tag, "_data"}, bad_data, 0);
    endtask

    initial begin
        int lost_low, lost_cs;
        bit ok;
        rst = 1'b1; VB = 1'b0; dma_en = 1'b1;
        clear_stats();
        repeat (3) step();
        check("rst_busrq_n", {31'd0, bus.busrq_n}, 1);
        check("rst_dma_cs",  {31'd0, bus.dma_cs}, 0);
        check("rst_ad",      {22'd0, bus.AD_DMA}, 0);
        check("rst_obj_addr", {22'd0, bus.obj_addr}, 0);
        check("rst_obj_data", {24'd0, bus.obj_data}, 0);
        check("rst_obj_we",  {31'd0, bus.obj_we}, 0);
        check("rst_initeo",  {31'd0, bus.INITEO}, 0);
        check("rst_overrun", {31'd0, overrun}, 0);
        rst = 1'b0;
        step();

        // Disabled: VB edge ignored and not counted as an overrun
        dma_en = 1'b0;
        clear_stats();
        pulse_vb();
        repeat (20) step();
        check("dis_busrq", rq_low, 0);
        check("dis_we", we_cnt, 0);
        check("dis_overrun", {31'd0, overrun}, 0);
        dma_en = 1'b1;
        step();

        // Normal frame, grant 3 clks after request
        clear_stats();
        VB = 1'b1;
        step();
        VB = 1'b0;
        check("trig_to_busrq", {31'd0, bus.busrq_n}, 0);
        run_done("norm_done");
        check("norm_we_cnt", we_cnt, 1024);
        sb_check("norm", 1'b0);
        check("norm_busrq_low", rq_low, 1030);
        check("norm_initeo_hi", ini_hi, 1028);
        check("norm_first_ad", first_ad, 0);
        check("norm_gnt_to_cs", first_cs - first_gnt, 1);
        check("norm_cs_to_we", first_we - first_cs, 2);
        check("norm_cs_to_last", last_we - first_cs, 1025);
        check("norm_overrun", {31'd0, overrun}, 0);

        // VB edge during transfer: sticky overrun, nothing queued
        clear_stats();
        pulse_vb();
        wait_ad("ovr_reach", 100);
        pulse_vb();
        check("ovr_set", {31'd0, overrun}, 1);
        run_done("ovr_done");
        repeat (50) step();
        check("ovr_no_queue_we", we_cnt, 1024);
        check("ovr_no_queue_rq", {31'd0, bus.busrq_n}, 1);
        clear_stats();
        pulse_vb();
        run_done("ovr2_done");
        check("ovr2_we_cnt", we_cnt, 1024);
        sb_check("ovr2", 1'b0);
        check("ovr_sticky", {31'd0, overrun}, 1);

        // Bus lost while rd_cnt=300: resume two addresses back
        clear_stats();
        pulse_vb();
        wait_ad("loss_reach", 299);
        force_hi = 1'b1;
        lost_low = 0;
        lost_cs  = 0;
        repeat (10) begin
            step();
            if (!bus.busrq_n) lost_low++;
            if (bus.dma_cs) lost_cs++;
        end
        force_hi = 1'b0;
        check("loss_busrq_low", lost_low, 10);
        check("loss_cs_off", lost_cs, 0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.dma_cs) begin
                ok = 1'b1;
                break;
            end
        end
        check("loss_regrant", {31'd0, ok}, 1);
        check("loss_resume_ad", {22'd0, bus.AD_DMA}, 298);
        run_done("loss_done");
        sb_check("loss", 1'b1);
        check("loss_cs_no_bus", cs_no_bus, 0);

        // Reset mid-transfer, then a clean full transfer
        clear_stats();
        pulse_vb();
        wait_ad("rstm_reach", 500);
        rst = 1'b1;
        #1;
        check("rstm_busrq_n", {31'd0, bus.busrq_n}, 1);
        check("rstm_dma_cs", {31'd0, bus.dma_cs}, 0);
        check("rstm_obj_we", {31'd0, bus.obj_we}, 0);
        check("rstm_initeo", {31'd0, bus.INITEO}, 0);
        step();
        rst = 1'b0;
        repeat (5) step();
        clear_stats();
        pulse_vb();
        run_done("rstm_done");
        check("rstm_we_cnt", we_cnt, 1024);
        sb_check("rstm", 1'b0);
        check("rstm_overrun", {31'd0, overrun}, 0);

        // Slow grant: 200 clks
        grant_dly = 200;
        clear_stats();
        pulse_vb();
        run_done("slow_done");
        check("slow_cs_no_bus", cs_no_bus, 0);
        check("slow_gnt_to_cs", first_cs - first_gnt, 1);
        check("slow_we_cnt", we_cnt, 1024);
        sb_check("slow", 1'b0);
        check("slow_busrq_low", rq_low, 1227);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtpopeye_dma.md
# jtpopeye_dma

Sprite DMA controller for the Popeye/Sky Skipper main board. On each vertical blank it takes the Z80 bus through the BUSRQ/BUSAK handshake. It then streams the top 1 kB of main work RAM (the object table) into the video object buffer and releases the bus. It sits between jtpopeye_main (busrq_n, busak_n, dma_cs, AD_DMA, DD_DMA, INITEO) and the object line-buffer logic.

## Interface
Parameters:
- AW, 10, object-table address width; transfer length is 2^AW bytes.
- RD_LAT, 2, clk cycles from AD_DMA change to valid DD_DMA (main RAM registers address, then data).

Ports:
- clk  in  1  system clock; all logic runs every clk, no clock enable.
- rst  in  1  asynchronous, active-high reset.
- dma_en  in  1  level; 0 blocks new requests; an ongoing transfer completes.
- VB  in  1  vertical blank; its rising edge triggers a transfer.
- busrq_n  out  1  Z80 bus request, active low.
- busak_n  in  1  Z80 bus acknowledge, active low.
- dma_cs  out  1  high while main RAM must serve AD_DMA.
- AD_DMA  out  AW  object-table read address.
- DD_DMA  in  8  main RAM read data.
- obj_addr  out  AW  object buffer write address.
- obj_data  out  8  object buffer write data.
- obj_we  out  1  object buffer write strobe, one clk per byte.
- INITEO  out  1  high from bus grant until bus release; CPU-readable busy flag.
- overrun  out  1  sticky; set when a VB edge arrives while not IDLE.

## Operation
- Reset values: busrq_n=1, dma_cs=0, AD_DMA=0, obj_addr=0, obj_data=0, obj_we=0, INITEO=0, overrun=0, state=IDLE, VB edge register=0.
- VB edge detector: registered VBl; `trig = VB & ~VBl`.
- States:
  - IDLE: if trig & dma_en, go to REQ. If trig & !dma_en, stay in IDLE and leave overrun unchanged.
  - REQ: busrq_n=0. Wait for busak_n==0, then go to XFER, with rd_cnt=0 and INITEO=1.
  - XFER: dma_cs=1, AD_DMA=rd_cnt, rd_cnt increments every clk. When rd_cnt reaches 2^AW-1, go to DRAIN on the next clk.
  - DRAIN: dma_cs stays 1 for RD_LAT more clks so the last bytes return, then go to RELEASE.
  - RELEASE: busrq_n=1, dma_cs=0. Wait for busak_n==1, then clear INITEO and go to IDLE.
- Write pipeline: a valid bit and address delay line of depth RD_LAT tracks each issued address. When the tail is valid, the block sets obj_we=1, obj_addr to the delayed address and obj_data=DD_DMA. Exactly 2^AW writes occur, in ascending address order.
- rd_cnt is AW bits wide and wraps naturally. The terminal test is on all-ones, not on overflow.
- busak_n rising during XFER or DRAIN (bus lost):
  - freeze rd_cnt and force dma_cs=0;
  - flush the pipeline (no obj_we);
  - return to REQ, then resume at the frozen rd_cnt minus RD_LAT, saturating at 0, so that no byte is skipped.
- trig while not IDLE sets overrun. It is never queued. overrun clears only on rst.
- rst asserted mid-transfer: all outputs go to their reset values immediately (busrq_n=1 releases the CPU). A partial object buffer is acceptable.

## Timing
- trig -> busrq_n low: 1 clk (registered).
- busak_n low -> first AD_DMA=0 with dma_cs=1: 1 clk.
- AD_DMA=n -> obj_we for address n: RD_LAT clks.
- Full transfer at AW=10, RD_LAT=2: from entering XFER to the last obj_we is 1024+2 clks, assuming no bus loss.
- busrq_n high -> INITEO low: 1 clk after busak_n is sampled high.
- busak_n is sampled synchronously; no extra synchroniser is needed because it comes from jtframe_z80 on clk.

## Structure
- Shared package jtpopeye_pkg holds:
  - the state enum (IDLE, REQ, XFER, DRAIN, RELEASE);
  - default constants OBJ_AW=10 and RAM_RD_LAT=2.
- Natural sub-module: jtpopeye_dma_pipe. It is the RD_LAT-deep delay line for the valid bit and address, with a flush input.
- The FSM, counter and edge detector stay in the top module.

## Test plan
- Normal frame: the RAM model returns DD_DMA = addr[7:0] ^ 8'h5A after 2 clks; pulse VB high; grant busak_n 3 clks after the request. Required: 1024 obj_we pulses, obj_data[n] = n[7:0]^5A, busrq_n low for 3+1+1024+2+release clks, INITEO bracketing the transfer.
- VB edge during XFER -> overrun=1 and no second transfer. The next VB edge after IDLE starts a new transfer while overrun stays 1.
- dma_en=0 with VB edge -> busrq_n stays 1, no obj_we, overrun=0.
- busak_n forced high at rd_cnt=300 for 10 clks -> busrq_n stays low. The transfer resumes at AD_DMA=298. All 1024 addresses are written exactly once, checked by a scoreboard (duplicates of 298/299 are allowed only if the data is identical).
- rst pulsed at rd_cnt=500 -> busrq_n=1, dma_cs=0, obj_we=0, INITEO=0 within the same clk. The next VB edge performs a full 1024-byte transfer.
- Slow grant: busak_n granted 200 clks late -> no dma_cs before the grant, and transfer data is correct.
